// File: rtl/fp16_pkg.sv
// Shared fp16 (1/5/10, bias 15) definitions used by the multiplier datapath and its arbiter.
package fp16_pkg;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;
  localparam int FP16_EXP_MAX = 30;

  typedef logic [15:0] fp16_t;

  function automatic logic fp16_sign(input fp16_t w);
    return w[15];
  endfunction

  function automatic logic [FP16_EXP_W-1:0] fp16_exp(input fp16_t w);
    return w[14:10];
  endfunction

  function automatic logic [FP16_MAN_W-1:0] fp16_man(input fp16_t w);
    return w[9:0];
  endfunction

endpackage

// File: rtl/fp16_mult_pipe.sv
// Truncating fp16 multiplier, MULT_LAT register stages deep; valid and tag travel with the data.
module fp16_mult_pipe
  import fp16_pkg::*;
#(
  parameter int MULT_LAT = 3,
  parameter int TAG_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  fp16_t            a,
  input  fp16_t            b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output fp16_t            p,
  output logic             ovf,
  output logic             unf
);

  localparam logic signed [6:0] BIAS_S    = 7'(FP16_BIAS);
  localparam logic signed [6:0] EXP_MAX_S = 7'(FP16_EXP_MAX);

  logic [FP16_EXP_W-1:0] ea_s, eb_s;
  logic [21:0]           frac_s;
  logic signed [6:0]     exp_s;
  logic [9:0]            man_s;
  fp16_t                 res_s;
  logic                  ovf_s, unf_s;

  logic [MULT_LAT-1:0]   vld_r, ovf_r, unf_r;
  logic [TAG_W-1:0]      tag_r [MULT_LAT];
  fp16_t                 dat_r [MULT_LAT];

  // product, normalisation and exception classification, all ahead of stage 0
  always_comb begin
    ea_s   = fp16_exp(a);
    eb_s   = fp16_exp(b);
    frac_s = {1'b1, fp16_man(a)} * {1'b1, fp16_man(b)};
    exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;
    res_s  = 16'h0000;
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    if (frac_s[21]) begin
      man_s = frac_s[20:11];
      exp_s = exp_s + 7'sd1;
    end else begin
      man_s = frac_s[19:10];
    end
    // zero and subnormal inputs flush silently, before any range check
    if (ea_s == 5'd0 || eb_s == 5'd0) begin
      res_s = 16'h0000;
    end else if (exp_s < 7'sd1) begin
      unf_s = 1'b1;
    end else if (exp_s > EXP_MAX_S) begin
      ovf_s = 1'b1;
    end else begin
      res_s = {fp16_sign(a) ^ fp16_sign(b), exp_s[4:0], man_s};
    end
  end

  // pipeline shift; data and tag only advance behind a valid so the last stage holds
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= '0;
      ovf_r <= '0;
      unf_r <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_r[i] <= '0;
        dat_r[i] <= 16'h0000;
      end
    end else begin
      vld_r[0] <= in_valid;
      ovf_r[0] <= in_valid & ovf_s;
      unf_r[0] <= in_valid & unf_s;
      if (in_valid) begin
        tag_r[0] <= in_tag;
        dat_r[0] <= res_s;
      end
      for (int i = 1; i < MULT_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        ovf_r[i] <= ovf_r[i-1];
        unf_r[i] <= unf_r[i-1];
        if (vld_r[i-1]) begin
          tag_r[i] <= tag_r[i-1];
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign out_valid = vld_r[MULT_LAT-1];
  assign out_tag   = tag_r[MULT_LAT-1];
  assign p         = dat_r[MULT_LAT-1];
  assign ovf       = ovf_r[MULT_LAT-1];
  assign unf       = unf_r[MULT_LAT-1];

endmodule

// File: rtl/fp16_mult_arbiter.sv
// Round-robin front end that shares one pipelined fp16 multiplier among NUM_REQ PE lanes.
module fp16_mult_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 3,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  rsp_ovf,
  output logic                  rsp_unf,
  output logic [ID_W+1:0]       inflight
);

  logic [ID_W-1:0]    ptr_r, gidx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               issue_s;
  fp16_t              a_s, b_s;
  logic [ID_W+1:0]    inflight_r;

  // rotating-priority grant: first valid lane at or after ptr_r, wrapping
  always_comb begin
    int  idx;
    logic found;
    grant_s = '0;
    gidx_s  = '0;
    a_s     = 16'h0000;
    b_s     = 16'h0000;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && !reset && req_valid[idx]) begin
        found        = 1'b1;
        grant_s[idx] = 1'b1;
        gidx_s       = ID_W'(idx);
        a_s          = req_a[16*idx +: 16];
        b_s          = req_b[16*idx +: 16];
      end else begin
        found = found;
      end
    end
    issue_s = found;
  end

  assign req_ready = grant_s;

  // pointer moves past the winner; holds when nothing was granted
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (issue_s) begin
      ptr_r <= (gidx_s == ID_W'(NUM_REQ - 1)) ? '0 : gidx_s + 1'b1;
    end
  end

  // occupancy: +1 on issue, -1 on retire, unchanged when both or neither
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_r <= '0;
    end else begin
      case ({issue_s, rsp_valid})
        2'b10:   inflight_r <= inflight_r + 1'b1;
        2'b01:   inflight_r <= inflight_r - 1'b1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign inflight = inflight_r;

  fp16_mult_pipe #(
    .MULT_LAT (MULT_LAT),
    .TAG_W    (ID_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_s),
    .in_tag    (gidx_s),
    .a         (a_s),
    .b         (b_s),
    .out_valid (rsp_valid),
    .out_tag   (rsp_id),
    .p         (rsp_data),
    .ovf       (rsp_ovf),
    .unf       (rsp_unf)
  );

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Directed bench for fp16_mult_arbiter: handshakes feed a scoreboard that is checked as responses retire.
module tb_fp16_mult_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_ovf, rsp_unf;
  logic [3:0]    inflight;

  typedef struct {
    int          id;
    logic [17:0] res;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          gq[$];
  logic [17:0] lane_exp [N];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  fp16_mult_arbiter #(.NUM_REQ(N), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_unf   (rsp_unf),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference product as {ovf, unf, data}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, f;
    logic [9:0] m;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return 18'h00000;
    f = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
    e = ea + eb - 15;
    if (f >= 2097152) begin
      e = e + 1;
      m = 10'((f / 2048) % 1024);
    end else begin
      m = 10'((f / 1024) % 1024);
    end
    if (e < 1)  return 18'h10000;
    if (e > 30) return 18'h20000;
    return {2'b00, a[15] ^ b[15], 5'(e), m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic set_lane(input int l, input logic [15:0] a, input logic [15:0] b,
                          input logic [17:0] e);
    req_a[16*l +: 16] = a;
    req_b[16*l +: 16] = b;
    lane_exp[l]       = e;
    req_valid[l]      = 1'b1;
  endtask

  task automatic wait_grant(input int l);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[l];
    end
    check("grant_timeout", got, 1);
    @(posedge clk);
    #1 req_valid[l] = 1'b0;
  endtask

  task automatic issue(input int l, input logic [15:0] a, input logic [15:0] b,
                       input logic [17:0] e);
    @(posedge clk);
    #1 set_lane(l, a, b, e);
    wait_grant(l);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_lane(input int l);
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    set_lane(l, a, b, model(a, b));
  endtask

  // scoreboard: retire responses, then record this cycle's handshakes
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sbq.delete();
    end else begin
      if (rsp_valid) begin
        check("rsp_unexpected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_result", {rsp_ovf, rsp_unf, rsp_data}, e.res);
          check("rsp_latency", cyc, e.due);
        end
      end else begin
        check("flags_idle", {rsp_ovf, rsp_unf}, 0);
        if (sbq.size() > 0) begin
          check("rsp_missing", sbq[0].due > cyc, 1);
          if (sbq[0].due <= cyc) void'(sbq.pop_front());
        end
      end
      check("ready_onehot", $countones(req_ready) <= 1, 1);
      for (int l = 0; l < N; l++) begin
        if (req_valid[l] && req_ready[l]) begin
          sbq.push_back('{l, lane_exp[l], cyc + LAT});
          gq.push_back(l);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    for (int l = 0; l < N; l++) lane_exp[l] = 18'h00000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", req_ready, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    req_valid = 4'h0;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 16'h0000);
    check("reset_flags", {rsp_ovf, rsp_unf}, 0);
    check("reset_inflight", inflight, 0);

    // single op and hold-after-valid
    issue(1, 16'h3E00, 16'h3E00, 18'h04080);
    idle(4);
    check("hold_data", rsp_data, 16'h4080);
    check("hold_id", rsp_id, 1);

    // arithmetic vectors and exceptions; ends with ptr back at 0
    issue(2, 16'h4000, 16'h4200, 18'h04600);
    issue(0, 16'h3C00, 16'hBC00, 18'h0BC00);
    issue(3, 16'h0000, 16'h4000, 18'h00000);
    issue(0, 16'h0400, 16'h0400, 18'h10000);
    issue(1, 16'h7800, 16'h7800, 18'h20000);
    issue(3, 16'h3C00, 16'h3C00, 18'h03C00);
    idle(5);

    // fairness: all lanes valid for 8 cycles, fresh random operands after each grant
    gq.delete();
    @(posedge clk);
    #1 for (int l = 0; l < N; l++) rand_lane(l);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_inflight", inflight, (k < 3) ? k : 3);
      g = 0;
      for (int l = 0; l < N; l++) if (req_ready[l]) g = l;
      @(posedge clk);
      #1 rand_lane(g);
    end
    req_valid = 4'h0;
    check("fair_count", gq.size(), 8);
    for (int i = 0; i < gq.size() && i < 8; i++) check("fair_order", gq[i], i % 4);
    idle(5);

    // sparse wrap: ptr=3, lanes 0 and 2 valid
    issue(2, 16'h4400, 16'h3800, 18'h04000);
    gq.delete();
    @(posedge clk);
    #1 set_lane(0, 16'h4000, 16'h4000, 18'h04400);
    set_lane(2, 16'h3C00, 16'h4500, 18'h04500);
    wait_grant(0);
    wait_grant(2);
    check("wrap_count", gq.size(), 2);
    if (gq.size() == 2) begin
      check("wrap_first", gq[0], 0);
      check("wrap_second", gq[1], 2);
    end

    // lane 1 drops valid before it is granted
    gq.delete();
    @(posedge clk);
    #1 set_lane(3, 16'h4000, 16'h3C00, 18'h04000);
    set_lane(1, 16'h4000, 16'h4000, 18'h04400);
    wait_grant(3);
    req_valid[1] = 1'b0;
    idle(6);
    check("drop_count", gq.size(), 1);
    if (gq.size() == 1) check("drop_lane", gq[0], 3);
    check("drop_sb_empty", sbq.size(), 0);

    // reset with a full pipeline
    gq.delete();
    @(posedge clk);
    #1 for (int l = 0; l < N; l++) rand_lane(l);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_inflight_before", inflight, 3);
    check("rst_ready_zero", req_ready, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_inflight_after", inflight, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_next_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = 4'h0;
    idle(6);
    check("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
